// File: rtl/alu_pkg.sv
// Shared ALU definitions: 5-bit ALU control codes used by the decoder, the ALU and the
// iterative multiplier, plus the multiplier's state and result-half encodings.
package alu_pkg;

  localparam logic [4:0] ALU_MUL    = 5'b01111;
  localparam logic [4:0] ALU_MULH   = 5'b10000;
  localparam logic [4:0] ALU_MULHSU = 5'b10001;
  localparam logic [4:0] ALU_MULHU  = 5'b10010;
  localparam logic [4:0] ALU_MULW   = 5'b10111;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } mul_state_t;

  // Which slice of the 2*XLEN product becomes the architectural result.
  typedef enum logic [1:0] {
    SEL_LO,
    SEL_HI,
    SEL_W
  } half_sel_t;

endpackage

// File: rtl/mul_unit_if.sv
// Request/response bundle between the execute stage and mul_unit; master is the
// pipeline side, slave is the multiplier.
interface mul_unit_if #(
  parameter int XLEN = 64
);

  logic            valid_i;
  logic            ready_o;
  logic [4:0]      alu_control_i;
  logic [XLEN-1:0] src_a_i;
  logic [XLEN-1:0] src_b_i;
  logic            flush_i;
  logic            valid_o;
  logic            ready_i;
  logic [XLEN-1:0] result_o;
  logic            busy_o;

  modport master (
    output valid_i, alu_control_i, src_a_i, src_b_i, flush_i, ready_i,
    input  ready_o, valid_o, result_o, busy_o
  );

  modport slave (
    input  valid_i, alu_control_i, src_a_i, src_b_i, flush_i, ready_i,
    output ready_o, valid_o, result_o, busy_o
  );

endinterface

// File: rtl/mul_operand_prep.sv
// Combinational opcode decode for mul_unit: operand magnitudes, result sign,
// iteration count and which half of the product to return.
module mul_operand_prep
  import alu_pkg::*;
#(
  parameter  int XLEN = 64,
  localparam int CW   = $clog2(XLEN) + 1
) (
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] mag_a,
  output logic [XLEN-1:0] mag_b,
  output logic            neg,
  output logic [CW-1:0]   iters,
  output half_sel_t       half_sel,
  output logic            supported
);

  // The most negative value maps to 2^(XLEN-1), which is exact as an unsigned magnitude.
  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v);
    return v[XLEN-1] ? (-v) : v;
  endfunction

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    mag_a     = a;
    mag_b     = b;
    neg       = 1'b0;
    iters     = CW'(XLEN);
    half_sel  = SEL_LO;
    supported = 1'b1;
    case (op)
      ALU_MUL: ;
      ALU_MULH: begin
        mag_a    = abs_val(a);
        mag_b    = abs_val(b);
        neg      = a[XLEN-1] ^ b[XLEN-1];
        half_sel = SEL_HI;
      end
      ALU_MULHSU: begin
        mag_a    = abs_val(a);
        neg      = a[XLEN-1];
        half_sel = SEL_HI;
      end
      ALU_MULHU: half_sel = SEL_HI;
      ALU_MULW: begin
        mag_a    = {{(XLEN-32){1'b0}}, a[31:0]};
        mag_b    = {{(XLEN-32){1'b0}}, b[31:0]};
        iters    = CW'(32);
        half_sel = SEL_W;
      end
      default: begin
        mag_a     = '0;
        mag_b     = '0;
        supported = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mul_unit.sv
// Iterative radix-2 shift-add RV64 M multiplier (MUL/MULH/MULHSU/MULHU/MULW) with a
// valid/ready result port. Define MUL_EARLY_TERM_EN to leave CALC once the multiplier is exhausted.
module mul_unit
  import alu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input logic       clk_i,
  input logic       rst_i,
  mul_unit_if.slave bus
);

  localparam int CW = $clog2(XLEN) + 1;

  mul_state_t        state, state_next;
  logic [2*XLEN-1:0] mcand, acc, acc_next, prod;
  logic [XLEN-1:0]   mplier, mplier_next, result_q, result_sel;
  logic [CW-1:0]     cnt, cnt_next, iters_q;
  half_sel_t         half_q;
  logic              neg_q;
  logic              accept, calc_last;

  logic [XLEN-1:0]   prep_mag_a, prep_mag_b;
  logic              prep_neg, prep_supported;
  logic [CW-1:0]     prep_iters;
  half_sel_t         prep_half;

  mul_operand_prep #(.XLEN(XLEN)) u_prep (
    .op        (bus.alu_control_i),
    .a         (bus.src_a_i),
    .b         (bus.src_b_i),
    .mag_a     (prep_mag_a),
    .mag_b     (prep_mag_b),
    .neg       (prep_neg),
    .iters     (prep_iters),
    .half_sel  (prep_half),
    .supported (prep_supported)
  );

  assign accept = bus.valid_i && (state == IDLE) && !bus.flush_i;

  // One shift-add step; the final step's sum feeds the result directly.
  always_comb begin
    acc_next    = mplier[0] ? (acc + mcand) : acc;
    mplier_next = mplier >> 1;
    cnt_next    = cnt + CW'(1);
`ifdef MUL_EARLY_TERM_EN
    calc_last   = (cnt_next == iters_q) || (mplier_next == '0);
`else
    calc_last   = (cnt_next == iters_q);
`endif
    prod        = neg_q ? (-acc_next) : acc_next;
    case (half_q)
      SEL_HI:  result_sel = prod[2*XLEN-1:XLEN];
      SEL_W:   result_sel = {{(XLEN-32){prod[31]}}, prod[31:0]};
      default: result_sel = prod[XLEN-1:0];
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (bus.flush_i) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_next = prep_supported ? CALC : DONE;
        CALC:    if (calc_last) state_next = DONE;
        DONE:    if (bus.ready_i) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.ready_o = (state == IDLE);
    bus.busy_o  = (state != IDLE);
    bus.valid_o = (state == DONE);
  end

  // NOTE: the datapath is a handful of flops, not a memory, so it is cleared on reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      iters_q  <= '0;
      neg_q    <= 1'b0;
      half_q   <= SEL_LO;
      result_q <= '0;
    end else if (accept) begin
      mcand   <= {{XLEN{1'b0}}, prep_mag_a};
      mplier  <= prep_mag_b;
      acc     <= '0;
      cnt     <= '0;
      iters_q <= prep_iters;
      neg_q   <= prep_neg;
      half_q  <= prep_half;
      if (!prep_supported) result_q <= '0;
    end else if (state == CALC && !bus.flush_i) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier_next;
      cnt    <= cnt_next;
      if (calc_last) result_q <= result_sel;
    end
  end

  assign bus.result_o = result_q;

endmodule

// File: tb/tb_mul_unit.sv
// Randomised scoreboard bench for mul_unit: stimulus pushes expected result/latency,
// a negedge monitor pops and compares whenever the unit presents a result.
module tb_mul_unit;
  import alu_pkg::*;

  localparam int XLEN = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mul_unit_if #(.XLEN(XLEN)) bus ();
  mul_unit #(.XLEN(XLEN)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  typedef struct {
    logic [63:0] result;
    int          lat;
    int          acc_cyc;
    bit          chk_lat;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  function automatic bit is_mul(input logic [4:0] op);
    return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_MULW};
  endfunction

  // Reference: 128-bit arithmetic on sign- or zero-extended operands.
  function automatic logic [63:0] ref_mul(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] ea, eb, p;
    logic [63:0]  w;
    ea = {64'b0, a};
    eb = {64'b0, b};
    case (op)
      ALU_MUL:    begin p = ea * eb; return p[63:0]; end
      ALU_MULH:   begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
      ALU_MULHSU: begin p = {{64{a[63]}}, a} * eb; return p[127:64]; end
      ALU_MULHU:  begin p = ea * eb; return p[127:64]; end
      ALU_MULW:   begin w = {32'b0, a[31:0]} * {32'b0, b[31:0]}; return {{32{w[31]}}, w[31:0]}; end
      default:    return 64'b0;
    endcase
  endfunction

  function automatic int exp_lat(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
    int n;
    int bl;
    logic [63:0] mb;
    if (!is_mul(op)) return 1;
    n  = (op == ALU_MULW) ? 32 : 64;
    mb = b;
    bl = 1;
    if (op == ALU_MULH && b[63]) mb = -b;
    if (op == ALU_MULW) mb = {32'b0, b[31:0]};
    for (int i = 0; i < 64; i++) if (mb[i]) bl = i + 1;
`ifdef MUL_EARLY_TERM_EN
    return ((bl < n) ? bl : n) + 1;
`else
    return n + 1 + 0 * bl + 0 * a[0];
`endif
  endfunction

  // Monitor: any presented result must be expected; it is retired when accepted.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.valid_o) begin
        if (sb_q.size() == 0) begin
          check("unexpected_valid", 64'd1, 64'd0);
        end else if (bus.ready_i) begin
          exp_t e;
          e = sb_q.pop_front();
          check("result", bus.result_o, e.result);
          if (e.chk_lat) check("latency", 64'(cyc - e.acc_cyc + 1), 64'(e.lat));
        end
      end
    end
  end

  task automatic issue(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                       input bit track, input bit chk_lat);
    bus.alu_control_i = op;
    bus.src_a_i       = a;
    bus.src_b_i       = b;
    bus.valid_i       = 1'b1;
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    if (track) begin
      exp_t e;
      e.result  = ref_mul(op, a, b);
      e.lat     = exp_lat(op, a, b);
      e.acc_cyc = cyc;
      e.chk_lat = chk_lat;
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (sb_q.size() == 0 && bus.ready_o) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      check("timeout", 64'd0, 64'd1);
      sb_q.delete();
      bus.flush_i = 1'b1;
      @(posedge clk);
      #1;
      bus.flush_i = 1'b0;
    end
  endtask

  task automatic run(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
    issue(op, a, b, 1'b1, 1'b1);
    wait_done();
  endtask

  function automatic logic [63:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 64'h8000_0000_0000_0000;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'(unsigned'($urandom_range(0, 20)));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  logic [4:0] ops [6];
  logic [63:0] ha, hb, hexp;

  initial begin
    ops = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_MULW, 5'b00011};
    bus.valid_i = 1'b0;
    bus.alu_control_i = '0;
    bus.src_a_i = '0;
    bus.src_b_i = '0;
    bus.flush_i = 1'b0;
    bus.ready_i = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid_o", 64'(bus.valid_o), 64'd0);
    check("rst_result_o", bus.result_o, 64'd0);
    check("rst_busy_o", 64'(bus.busy_o), 64'd0);
    check("rst_ready_o", 64'(bus.ready_o), 64'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run(ALU_MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD);
    run(ALU_MULH, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    run(ALU_MUL, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    run(ALU_MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    run(ALU_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    run(ALU_MULW, 64'h1_0000_FFFF, 64'h0000_0000_0001_0000);
    run(5'b00000, 64'h1234, 64'h5678);
    run(ALU_MUL, 64'd5, 64'd9);

    // Back-pressure: result must hold while ready_i is low.
    ha = {$urandom, $urandom};
    hb = {$urandom, $urandom};
    hexp = ref_mul(ALU_MULHU, ha, hb);
    bus.ready_i = 1'b0;
    issue(ALU_MULHU, ha, hb, 1'b1, 1'b0);
    for (int i = 0; i < 200 && !bus.valid_o; i++) begin
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 5; i++) begin
      check("hold_result", bus.result_o, hexp);
      check("hold_valid", 64'(bus.valid_o), 64'd1);
      check("hold_ready_o", 64'(bus.ready_o), 64'd0);
      @(posedge clk);
      #1;
    end
    bus.ready_i = 1'b1;
    @(posedge clk);
    #1;
    check("idle_after_handshake", 64'(bus.ready_o), 64'd1);
    wait_done();

    // Flush in CALC cycle 10.
    issue(ALU_MUL, 64'd11, 64'd13, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    check("busy_before_flush", 64'(bus.busy_o), 64'd1);
    bus.flush_i = 1'b1;
    @(posedge clk);
    #1;
    bus.flush_i = 1'b0;
    check("flush_calc_ready", 64'(bus.ready_o), 64'd1);
    repeat (70) @(posedge clk);
    #1;
    check("flush_calc_no_valid", 64'(bus.valid_o), 64'd0);

    // Flush beats a same-cycle request.
    bus.alu_control_i = ALU_MUL;
    bus.src_a_i = 64'd2;
    bus.src_b_i = 64'd2;
    bus.valid_i = 1'b1;
    bus.flush_i = 1'b1;
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    bus.flush_i = 1'b0;
    check("flush_accept_ready", 64'(bus.ready_o), 64'd1);
    check("flush_accept_busy", 64'(bus.busy_o), 64'd0);
    repeat (70) @(posedge clk);
    #1;
    check("flush_accept_no_valid", 64'(bus.valid_o), 64'd0);
    run(ALU_MUL, 64'd3, 64'd4);

    for (int i = 0; i < 30; i++) begin
      run(ops[$urandom_range(0, 5)], rand_operand(), rand_operand());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mul_unit.md
# mul_unit

Iterative RV64 M-extension multiplier in the execute stage. Consumes the 5-bit ALU control code from the ALU decoder together with both operands, and computes MUL, MULH, MULHSU, MULHU and MULW with a radix-2 shift-add datapath. Results are returned over a valid/ready handshake, so the pipeline stalls on `busy_o` while a multiply is in flight.

## Interface
- `XLEN`, default 64: operand and result width.
- `clk_i`  in  1  clock; all logic is rising-edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `valid_i`  in  1  request valid.
- `ready_o`  out  1  unit can accept a request; high iff the state is IDLE.
- `alu_control_i`  in  5  operation code.
- `src_a_i`  in  XLEN  rs1 operand.
- `src_b_i`  in  XLEN  rs2 operand.
- `flush_i`  in  1  kill any in-flight operation.
- `valid_o`  out  1  `result_o` is valid.
- `ready_i`  in  1  consumer accepts the result.
- `result_o`  out  XLEN  registered result.
- `busy_o`  out  1  the state is not IDLE.

## Operation
- Operation codes:
  - 01111 MUL: low XLEN bits.
  - 10000 MULH: signed×signed, high half.
  - 10001 MULHSU: signed a × unsigned b, high half.
  - 10010 MULHU: unsigned×unsigned, high half.
  - 10111 MULW: low 32 bits of `src_a_i[31:0]`×`src_b_i[31:0]`, sign-extended to XLEN.
- Any other code is accepted. It skips CALC and produces a result of 0.
- A request is accepted when `valid_i && ready_o && !flush_i`. Opcode, operand magnitudes and the result sign (sign of a XOR sign of b, for signed operands only) are latched at that edge.
- Datapath: a 2·XLEN-bit unsigned accumulator. Each CALC cycle, if the multiplier LSB is 1, the shifted multiplicand is added; then the multiplicand shifts left by 1 and the multiplier shifts right by 1.
- On exit from CALC, the product is negated if the result sign is set. The required half is then selected and registered into `result_o`.
- States:
  - IDLE → CALC on accept; IDLE → DONE on accept of an unsupported code.
  - CALC → DONE once the iteration count reaches N, where N = XLEN, or N = 32 for MULW.
  - DONE → IDLE when `ready_i` is high.
- `flush_i` high in any state: next state is IDLE, `valid_o` goes low and the result is discarded. Flush beats a same-cycle accept, so the request is not taken.
- `rst_i` behaves as flush and also clears `result_o` and all datapath registers.
- Overflow case: the most negative value × −1 gives magnitude 2^(XLEN−1), which fits the unsigned datapath. No special casing is needed.

## Timing
- Reset values: `valid_o`=0, `result_o`=0, `busy_o`=0, `ready_o`=1. The state is IDLE.
- Latency is measured from the accept edge; `valid_o` rises on the edge N+1 cycles later.
  - MUL/MULH/MULHSU/MULHU with XLEN=64: 65 cycles.
  - MULW: 33 cycles.
  - Unsupported code: 1 cycle.
- `valid_o` and `result_o` hold stable while `ready_i` is low.
- The next accept is possible in the cycle after the DONE→IDLE handshake. There is no back-to-back overlap.
- `ready_o` and `busy_o` are combinational from state only. They never depend on `valid_i`.

## Configuration
- `MUL_EARLY_TERM_EN` defined: CALC also exits to DONE at the edge where the remaining multiplier register is zero, checked after the shift. Minimum CALC length is 1 cycle; maximum is N. Example: MUL by 5 gives 3 CALC cycles, so latency is 4. The result is bit-identical to the fixed-latency mode.
- Undefined: CALC always runs exactly N cycles, giving a deterministic latency.

## Structure
- Shared `alu_pkg` holds:
  - the 5-bit ALU control code localparams (`ALU_MUL`, `ALU_MULH`, `ALU_MULHSU`, `ALU_MULHU`, `ALU_MULW`), shared with the ALU decoder and ALU;
  - the `mul_state_t` enum {IDLE, CALC, DONE}.
- Sub-module `mul_operand_prep` (combinational) maps opcode and operands to the operand magnitudes, the result sign, the iteration count N, and the half-select.

## Test plan
- MUL 7 × −3 → `result_o`=0xFFFF_FFFF_FFFF_FFEB; `valid_o` 65 cycles after accept.
- MULH 0x8000_0000_0000_0000 × 0xFFFF_FFFF_FFFF_FFFF → 0. The same operands with MUL → 0x8000_0000_0000_0000.
- MULHSU a=−1, b=0xFFFF_FFFF_FFFF_FFFF → 0xFFFF_FFFF_FFFF_FFFF. MULHU with the same operands → 0xFFFF_FFFF_FFFF_FFFE.
- MULW 0x1_0000_FFFF × 0x0000_0000_0001_0000 → 0xFFFF_FFFF_FFFF_0000; `valid_o` 33 cycles after accept.
- Hold `ready_i` low for 5 cycles in DONE → `result_o` stable and `ready_o` low; on `ready_i`, IDLE follows on the next cycle.
- Assert `flush_i` at CALC cycle 10, and separately assert it in the same cycle as `valid_i` → no `valid_o`, `ready_o`=1 next cycle. A following MUL 3 × 4 → 12.
